// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// Multiply is shift-add (one multiplier bit per RUN cycle) and divide is
// restoring (one quotient bit per RUN cycle). Both operate on magnitudes.
// The FIX cycle applies the result signs and writes HI/LO. mthi/mtlo write
// HI/LO directly at the acceptance edge.
//
// Optional feature macro: MDU_FAST_MUL_EN. When it is defined, mult/multu
// compute the product with an array multiplier at acceptance and go straight
// to FIX, so the result lands one cycle after acceptance.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted when busy=0
//   op     in   000 mult, 001 multu, 010 div, 011 divu, 101 mthi, 111 mtlo,
//               100/110 no-op
//   src_a  in   multiplicand / dividend / mthi-mtlo data
//   src_b  in   multiplier / divisor
//   busy   out  mult/div in flight
//   done   out  one-cycle pulse after HI/LO take a mult/div result
//   hi     out  HI register
//   lo     out  LO register
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;       // mult: {partial, multiplier}; div: {rem, quot}
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_save;    // raw dividend, returned as HI on divide-by-zero
    logic               is_div;
    logic               neg_q;     // product / quotient sign
    logic               neg_r;     // remainder sign (dividend's sign)
    logic               div0;

    logic               accept;
    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_init;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    assign accept = start && (state_q == IDLE);
    assign sgn    = !op[0];
    assign mag_a  = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b  = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
    assign busy   = (state_q != IDLE);

    always_comb begin
        acc_init = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
`ifdef MDU_FAST_MUL_EN
        if (!op[1])
            acc_init = (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
`endif
    end

    // One shift-add step and one restoring-divide trial subtraction.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

    // Sign correction. The signed-overflow case (MIN / -1) falls out naturally:
    // magnitude quotient is 2^(W-1) with a positive sign, remainder 0.
    assign prod = neg_q ? -acc : acc;
    assign quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !op[2]) begin
                    state_d = RUN;
`ifdef MDU_FAST_MUL_EN
                    if (!op[1])
                        state_d = FIX;
`endif
                end
            end
            RUN:     if (cnt == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_save <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && !op[2]) begin
                        cnt    <= CW'(WIDTH - 1);
                        acc    <= acc_init;
                        opnd   <= op[1] ? mag_b : mag_a;
                        a_save <= src_a;
                        is_div <= op[1];
                        neg_q  <= sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r  <= sgn && src_a[WIDTH-1];
                        div0   <= op[1] && (src_b == '0);
                    end else if (accept && op[0]) begin
                        if (op[1]) lo <= src_a;
                        else       hi <= src_a;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        if (!trial[WIDTH])
                            acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end else if (div0) begin
                        hi <= a_save;
                        lo <= '1;
                    end else begin
                        hi <= rem;
                        lo <= quot;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed testbench for mdu_seq (WIDTH=32): hand-computed results, latency,
// handshake, corner cases and reset behaviour.
module tb_mdu_seq;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b100;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int compared = 0;
    int mismatched = 0;

    mdu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Drive one request across a single rising edge; returns 1 ns after it.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b100; src_a = 'x; src_b = 'x;
    endtask

    // Count rising edges until done is seen; -1 if the bound expires.
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin k = i; break; end
        end
    endtask

    task automatic test_reset;
        #3;
        compared++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want 0/0/0/0", hi, lo, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_mult;
        int k;
        logic [W-1:0] old_hi;
        old_hi = hi;
        issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
        compared++;
        if (busy !== 1'b1 || hi !== old_hi) begin
            mismatched++;
            $display("FAIL mult_accept: busy=%b hi=%h, want 1 %h", busy, hi, old_hi);
        end
        wait_done(k);
        compared++;
        if (k !== MUL_LAT) begin
            mismatched++;
            $display("FAIL mult_latency: got %0d cycles, want %0d", k, MUL_LAT);
        end
        compared++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL mult_result: hi=%h lo=%h busy=%b, want ffffffff fffffffa 0", hi, lo, busy);
        end
        @(posedge clk); #1;
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL done_pulse_width: done=%b, want 0", done);
        end
    endtask

    task automatic test_multu;
        int k;
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(k);
        compared++;
        if (k !== MUL_LAT || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            mismatched++;
            $display("FAIL multu: lat=%0d hi=%h lo=%h, want %0d fffffffe 00000001", k, hi, lo, MUL_LAT);
        end
    endtask

    task automatic test_div;
        int k;
        issue(3'b010, -32'sd7, 32'd2);
        wait_done(k);
        compared++;
        if (k !== DIV_LAT || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("FAIL div_neg_pos: lat=%0d hi=%h lo=%h, want %0d ffffffff fffffffd", k, hi, lo, DIV_LAT);
        end
        issue(3'b010, 32'd7, -32'sd2);
        wait_done(k);
        compared++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'h0000_0001) begin
            mismatched++;
            $display("FAIL div_pos_neg: hi=%h lo=%h, want 00000001 fffffffd", hi, lo);
        end
        issue(3'b011, 32'hFFFF_FFF0, 32'd16);
        wait_done(k);
        compared++;
        if (lo !== 32'h0FFF_FFFF || hi !== 32'h0) begin
            mismatched++;
            $display("FAIL divu: hi=%h lo=%h, want 00000000 0fffffff", hi, lo);
        end
    endtask

    task automatic test_div_corners;
        int k;
        issue(3'b011, 32'd100, 32'd0);
        wait_done(k);
        compared++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'd100) begin
            mismatched++;
            $display("FAIL divu_by_zero: hi=%h lo=%h, want 00000064 ffffffff", hi, lo);
        end
        issue(3'b010, -32'sd5, 32'd0);
        wait_done(k);
        compared++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB) begin
            mismatched++;
            $display("FAIL div_by_zero: hi=%h lo=%h, want fffffffb ffffffff", hi, lo);
        end
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(k);
        compared++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            mismatched++;
            $display("FAIL div_overflow: hi=%h lo=%h, want 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_busy_ignore;
        int k;
        issue(3'b011, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b111; src_a = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b100;
        compared++;
        if (lo === 32'h1234 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_ignore_mid: lo=%h busy=%b, want lo!=00001234 busy=1", lo, busy);
        end
        wait_done(k);
        compared++;
        if (k < 0 || lo !== 32'd14 || hi !== 32'd2) begin
            mismatched++;
            $display("FAIL busy_ignore_result: k=%0d hi=%h lo=%h, want 00000002 0000000e", k, hi, lo);
        end
    endtask

    task automatic test_mthi;
        issue(3'b101, 32'hABCD, 32'h0);
        compared++;
        if (hi !== 32'hABCD || lo !== 32'd14 || done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL mthi: hi=%h lo=%h done=%b busy=%b, want 0000abcd 0000000e 0 0", hi, lo, done, busy);
        end
        issue(3'b111, 32'h5555, 32'h0);
        compared++;
        if (lo !== 32'h5555 || hi !== 32'hABCD || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b, want 0000abcd 00005555 0", hi, lo, busy);
        end
        issue(3'b110, 32'h9999, 32'h0);
        @(posedge clk); #1;
        compared++;
        if (lo !== 32'h5555 || hi !== 32'hABCD || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL noop: hi=%h lo=%h busy=%b done=%b, want 0000abcd 00005555 0 0", hi, lo, busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int k;
        issue(3'b011, 32'd50, 32'd8);
        wait_done(k);
        // Done cycle: a new request is accepted at the edge ending it.
        @(negedge clk);
        start = 1'b1; op = 3'b011; src_a = 32'd9; src_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b100;
        compared++;
        if (busy !== 1'b1 || lo !== 32'd6 || hi !== 32'd2) begin
            mismatched++;
            $display("FAIL b2b_accept: busy=%b hi=%h lo=%h, want 1 00000002 00000006", busy, hi, lo);
        end
        wait_done(k);
        compared++;
        if (k !== DIV_LAT || lo !== 32'd2 || hi !== 32'd1) begin
            mismatched++;
            $display("FAIL b2b_result: lat=%0d hi=%h lo=%h, want %0d 00000001 00000002", k, hi, lo, DIV_LAT);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        int seen;
        issue(3'b001, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, want 0/0/0/0", hi, lo, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL reset_discard: %0d cycles with done/busy, want 0", seen);
        end
        issue(3'b001, 32'd6, 32'd7);
        wait_done(k);
        compared++;
        if (k !== MUL_LAT || lo !== 32'd42 || hi !== 32'd0) begin
            mismatched++;
            $display("FAIL after_reset_op: lat=%0d hi=%h lo=%h, want %0d 00000000 0000002a", k, hi, lo, MUL_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_corners();
        test_busy_ignore();
        test_mthi();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers, the next generation of the pipeline's single-cycle MDU. It sits beside the ALU in the execute stage. It accepts one operation per start/busy handshake and runs signed or unsigned multiply and divide iteratively over WIDTH cycles. It supports direct HI/LO writes and defines results for divide-by-zero and signed overflow.

## Interface
- WIDTH, 32, operand width and HI/LO width; even, at least 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted on a rising edge when busy=0.
- op  in  3  encoding:
  - 000 mult; 001 multu; 010 div; 011 divu.
  - 101 mthi; 111 mtlo.
  - 100, 110 no-op.
- src_a  in  WIDTH  multiplicand / dividend / mthi-mtlo data.
- src_b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while a mult/div is in flight.
- done  out  1  one-cycle pulse when HI/LO take a mult/div result.
- hi  out  WIDTH  HI register (mfhi source).
- lo  out  WIDTH  LO register (mflo source).

## Operation
- States:
  - IDLE -> RUN on an accepted mult/multu/div/divu.
  - RUN -> FIX after WIDTH iterations.
  - FIX -> IDLE.
- Acceptance:
  - start with busy=1 is ignored: no queueing, no error.
  - op and operands are sampled only at acceptance and may change afterwards.
- mthi/mtlo:
  - Accepted in IDLE.
  - Writes src_a to hi or lo at the acceptance edge; the other register is unchanged.
  - No busy, no done.
- No-op codes (100, 110): accepted; no state change.
- Signed ops latch operand magnitudes plus result signs at acceptance.
- Multiply: shift-add, one multiplier bit per RUN cycle, 2*WIDTH-bit accumulator.
- Divide: restoring division, one quotient bit per RUN cycle.
- FIX stage:
  - Applies the sign correction. Signed remainder takes the dividend's sign.
  - Writes HI/LO:
    - mult: hi=product[2W-1:W], lo=product[W-1:0].
    - div: hi=remainder, lo=quotient.
- Divide by zero (src_b=0), signed or unsigned: lo=all ones, hi=src_a.
- Signed overflow (div, src_a=most-negative, src_b=-1): lo=most-negative, hi=0.
- Reset:
  - Any state -> IDLE.
  - hi=0, lo=0, busy=0, done=0.
  - An in-flight operation is discarded.

## Timing
- Mult/div accepted at edge E0:
  - busy=1 from E0 through E(WIDTH+1).
  - hi/lo update at E(WIDTH+1).
  - done=1 for the cycle following E(WIDTH+1); busy=0 in that same cycle.
- Latency: WIDTH+1 cycles from acceptance to result visible.
- New start may be accepted at the edge ending the done cycle, giving back-to-back throughput of one op per WIDTH+2 cycles.
- mthi/mtlo: hi/lo visible the cycle after acceptance.
- hi/lo hold their old values throughout RUN and FIX until the FIX write.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MDU_FAST_MUL_EN:
  - Defined: mult/multu use a single-cycle array multiplier. Accept at E0, FIX at E1, hi/lo update and busy drops at E1, done in the following cycle. Latency is 1 cycle; divide is unchanged.
  - Undefined: iterative multiply as specified above.

## Test plan
- Signed multiply, WIDTH=32: mult src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. done exactly 33 cycles after acceptance edge, or 1 cycle with MDU_FAST_MUL_EN.
- Unsigned multiply: multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide: div -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide corner cases:
  - divu 100 / 0 -> lo=0xFFFFFFFF, hi=100.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake:
  - start a div, then pulse start with mtlo 0x1234 at cycle 5 -> ignored; lo ends as the quotient.
  - Then mthi 0xABCD in IDLE -> hi=0xABCD next cycle, lo unchanged, no done.
- Reset mid-operation: deassert rst_n at cycle 10 of a mult -> hi=lo=0, busy=0 immediately, no done pulse; the next op completes normally.
